// File: rtl/montgomery_pkg.sv
// Shared types and sizing helpers for the Montgomery squaring chain.
package montgomery_pkg;

  // Number of REGISTER_SIZE blocks making up one BITS_IN_NUM operand.
  function automatic int num_blocks(input int bits, input int reg_size);
    return bits / reg_size;
  endfunction

  // Counter width able to index n items, never narrower than one bit.
  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, SQUARE, DRAIN} chain_state_t;

  typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_CALC, RD_OUT} red_state_t;

endpackage

// File: rtl/fsm_multiplier_parallel.sv
// Collects NUM_BLOCKS operand blocks, then presents the full double-width
// product with a one-cycle valid. Stays idle after that until reset.
module fsm_multiplier_parallel
  import montgomery_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [REGISTER_SIZE-1:0]   n_i,
  input  logic [REGISTER_SIZE-1:0]   m_i,
  input  logic                       valid_i,
  output logic [2*BITS_IN_NUM-1:0]   product_o,
  output logic                       valid_o
);
  localparam int NB = num_blocks(BITS_IN_NUM, REGISTER_SIZE);
  localparam int CW = ctr_w(NB);

  logic [BITS_IN_NUM-1:0] n_q, m_q;
  logic [CW-1:0]          cnt_q;
  logic                   done_q, vld_q;

  // Operand capture, LSB block first; product valid the cycle after the last block.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (valid_i && !done_q) begin
        n_q[cnt_q*REGISTER_SIZE +: REGISTER_SIZE] <= n_i;
        m_q[cnt_q*REGISTER_SIZE +: REGISTER_SIZE] <= m_i;
        if (int'(cnt_q) == NB-1) begin
          cnt_q  <= '0;
          done_q <= 1'b1;
          vld_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign product_o = {{BITS_IN_NUM{1'b0}}, n_q} * {{BITS_IN_NUM{1'b0}}, m_q};
  assign valid_o   = vld_q;

endmodule

// File: rtl/montgomery_reduce_parallel.sv
// Montgomery reduction of a double-width product: pulls N and k from their
// block streamers, computes T*2^-R mod N, streams the result LSB block first.
module montgomery_reduce_parallel
  import montgomery_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048,
  parameter int R             = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [2*BITS_IN_NUM-1:0]   product_i,
  input  logic                       valid_i,
  input  logic [REGISTER_SIZE-1:0]   N_i,
  input  logic [REGISTER_SIZE-1:0]   k_i,
  output logic                       consumed_N_o,
  output logic                       consumed_k_o,
  output logic [REGISTER_SIZE-1:0]   block_o,
  output logic                       valid_o
);
  localparam int NB = num_blocks(BITS_IN_NUM, REGISTER_SIZE);
  localparam int KB = R / REGISTER_SIZE;
  localparam int LB = (NB > KB) ? NB : KB;
  localparam int CW = ctr_w(LB);
  localparam int SW = ((2*BITS_IN_NUM > R+BITS_IN_NUM) ? 2*BITS_IN_NUM : R+BITS_IN_NUM) + 1;

  red_state_t               st_q, st_d;
  logic [CW-1:0]            cnt_q;
  logic [2*BITS_IN_NUM-1:0] t_q;
  logic [BITS_IN_NUM-1:0]   n_q, res_q, res_d;
  logic [R-1:0]             k_q, mm;
  logic [SW-1:0]            t_ext, n_ext, sum, qt;

  // Reduction step: m = T*k mod 2^R, t = (T + m*N) / 2^R, one conditional subtract.
  always_comb begin
    t_ext = SW'(t_q);
    n_ext = SW'(n_q);
    mm    = t_ext[R-1:0] * k_q;
    sum   = t_ext + SW'(mm) * n_ext;
    qt    = sum >> R;
    res_d = (qt >= n_ext) ? BITS_IN_NUM'(qt - n_ext) : BITS_IN_NUM'(qt);
  end

  // Sequencing: take product, stream in N/k, compute, stream result out.
  always_comb begin
    st_d = st_q;
    case (st_q)
      RD_IDLE: if (valid_i) st_d = RD_LOAD;
      RD_LOAD: if (int'(cnt_q) == LB-1) st_d = RD_CALC;
      RD_CALC: st_d = RD_OUT;
      RD_OUT:  if (int'(cnt_q) == NB-1) st_d = RD_IDLE;
    endcase
  end

  assign consumed_N_o = (st_q == RD_LOAD) && (int'(cnt_q) < NB);
  assign consumed_k_o = (st_q == RD_LOAD) && (int'(cnt_q) < KB);
  assign valid_o      = (st_q == RD_OUT);
  assign block_o      = res_q[cnt_q*REGISTER_SIZE +: REGISTER_SIZE];

  // State register and datapath captures.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q  <= RD_IDLE;
      cnt_q <= '0;
      t_q   <= '0;
      n_q   <= '0;
      k_q   <= '0;
      res_q <= '0;
    end else begin
      st_q <= st_d;
      case (st_q)
        RD_IDLE: begin
          cnt_q <= '0;
          if (valid_i) t_q <= product_i;
        end
        RD_LOAD: begin
          if (consumed_N_o) n_q[cnt_q*REGISTER_SIZE +: REGISTER_SIZE] <= N_i;
          if (consumed_k_o) k_q[cnt_q*REGISTER_SIZE +: REGISTER_SIZE] <= k_i;
          cnt_q <= (int'(cnt_q) == LB-1) ? '0 : cnt_q + CW'(1);
        end
        RD_CALC: res_q <= res_d;
        RD_OUT:  cnt_q <= (int'(cnt_q) == NB-1) ? '0 : cnt_q + CW'(1);
      endcase
    end
  end

endmodule

// File: rtl/square_round_ctr.sv
// Counts reducer output blocks into rounds; flags round end, final round,
// and produces the registered multiplier restart pulse.
module square_round_ctr
  import montgomery_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048,
  parameter int MAX_SQUARINGS = 2048,
  localparam int RW = $clog2(MAX_SQUARINGS+1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          red_valid_i,
  input  logic [RW-1:0] num_squarings_i,
  output logic          end_of_round_o,
  output logic [RW-1:0] round_o,
  output logic          final_round_o,
  output logic          mul_rst_o
);
  localparam int NB = num_blocks(BITS_IN_NUM, REGISTER_SIZE);
  localparam int CW = ctr_w(NB);

  logic [CW-1:0] blk_q;
  logic [RW-1:0] round_q;
  logic          mul_rst_q;

  assign end_of_round_o = red_valid_i && (int'(blk_q) == NB-1);
  assign final_round_o  = (round_q == num_squarings_i);
  assign round_o        = round_q;
  assign mul_rst_o      = mul_rst_q;

  // Block/round counters; rounds start at 1 when an operation begins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blk_q     <= '0;
      round_q   <= '0;
      mul_rst_q <= 1'b0;
    end else begin
      mul_rst_q <= end_of_round_o;
      if (clear_i) begin
        blk_q   <= '0;
        round_q <= RW'(1);
      end else if (red_valid_i) begin
        blk_q <= end_of_round_o ? '0 : blk_q + CW'(1);
        if (end_of_round_o && !final_round_o) round_q <= round_q + RW'(1);
      end
    end
  end

endmodule

// File: rtl/montgomery_square_chain.sv
// Programmable chain of Montgomery squarings: loads one operand, loops the
// reducer output back into the multiplier S times, emits final or all rounds.
module montgomery_square_chain
  import montgomery_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 2048,
  parameter int R             = 4096,
  parameter int MAX_SQUARINGS = 2048,
  localparam int RW = $clog2(MAX_SQUARINGS+1)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] N_in,
  input  logic [REGISTER_SIZE-1:0] k_in,
  output logic                     consumed_N_out,
  output logic                     consumed_k_out,
  input  logic [REGISTER_SIZE-1:0] block_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [RW-1:0]            num_squarings_in,
  input  logic                     emit_all_in,
  output logic [REGISTER_SIZE-1:0] block_out,
  output logic                     valid_out,
  output logic [RW-1:0]            round_out,
  output logic                     last_out,
  output logic                     busy_out
);
  localparam int NB = num_blocks(BITS_IN_NUM, REGISTER_SIZE);
  localparam int CW = ctr_w(NB);

  chain_state_t             state_q, state_d;
  logic [CW-1:0]            load_cnt_q, load_idx;
  logic [RW-1:0]            s_q, s_eff;
  logic                     emit_q, load_done_q;
  logic [REGISTER_SIZE-1:0] block_q;
  logic                     valid_q, last_q;
  logic [RW-1:0]            round_q;

  logic                     accept, first, load_last;
  logic                     mul_v, mul_rst, mul_valid;
  logic [REGISTER_SIZE-1:0] mul_blk;
  logic [2*BITS_IN_NUM-1:0] mul_prod;
  logic                     red_valid;
  logic [REGISTER_SIZE-1:0] red_blk;
  logic                     eor, final_rnd, ctr_mul_rst;
  logic [RW-1:0]            ctr_round;

  assign ready_out = (state_q == LOAD) || (state_q == IDLE && !last_q);
  assign busy_out  = (state_q != IDLE) || last_q;
  assign accept    = valid_in && ready_out;
  assign first     = accept && (state_q == IDLE);
  assign s_eff     = first ? num_squarings_in : s_q;
  assign load_idx  = (state_q == IDLE) ? '0 : load_cnt_q;
  assign load_last = accept && (int'(load_idx) == NB-1);

  // Loaded blocks seed the multiplier; during SQUARE the reducer output loops back.
  assign mul_v   = (accept && s_eff != '0) || (state_q == SQUARE && red_valid);
  assign mul_blk = (state_q == SQUARE) ? red_blk : block_in;
  assign mul_rst = rst_in || load_done_q || ctr_mul_rst;

  fsm_multiplier_parallel #(
    .REGISTER_SIZE(REGISTER_SIZE), .BITS_IN_NUM(BITS_IN_NUM)
  ) u_mul (
    .clk_i(clk_in), .rst_i(mul_rst), .n_i(mul_blk), .m_i(mul_blk),
    .valid_i(mul_v), .product_o(mul_prod), .valid_o(mul_valid)
  );

  montgomery_reduce_parallel #(
    .REGISTER_SIZE(REGISTER_SIZE), .BITS_IN_NUM(BITS_IN_NUM), .R(R)
  ) u_red (
    .clk_i(clk_in), .rst_i(rst_in), .product_i(mul_prod), .valid_i(mul_valid),
    .N_i(N_in), .k_i(k_in), .consumed_N_o(consumed_N_out),
    .consumed_k_o(consumed_k_out), .block_o(red_blk), .valid_o(red_valid)
  );

  square_round_ctr #(
    .REGISTER_SIZE(REGISTER_SIZE), .BITS_IN_NUM(BITS_IN_NUM),
    .MAX_SQUARINGS(MAX_SQUARINGS)
  ) u_ctr (
    .clk_i(clk_in), .rst_i(rst_in), .clear_i(first), .red_valid_i(red_valid),
    .num_squarings_i(s_q), .end_of_round_o(eor), .round_o(ctr_round),
    .final_round_o(final_rnd), .mul_rst_o(ctr_mul_rst)
  );

  // Next state: load, then square until the final round, which drains out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOAD: begin
        if (load_last) begin
          if (s_eff == '0)          state_d = IDLE;
          else if (s_eff == RW'(1)) state_d = DRAIN;
          else                      state_d = SQUARE;
        end else if (accept) begin
          state_d = LOAD;
        end
      end
      SQUARE: if (eor && (ctr_round + RW'(1) == s_q)) state_d = DRAIN;
      DRAIN:  if (eor) state_d = IDLE;
    endcase
  end

  // State, operation settings, load counter and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      load_cnt_q  <= '0;
      s_q         <= '0;
      emit_q      <= 1'b0;
      load_done_q <= 1'b0;
      block_q     <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      round_q     <= '0;
    end else begin
      state_q     <= state_d;
      load_done_q <= load_last && (s_eff != '0);
      if (first) begin
        s_q    <= num_squarings_in;
        emit_q <= emit_all_in;
      end
      if (accept) load_cnt_q <= load_last ? '0 : load_idx + CW'(1);
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      if (accept && s_eff == '0) begin
        valid_q <= 1'b1;
        block_q <= block_in;
        round_q <= '0;
        last_q  <= load_last;
      end else if (red_valid && (state_q == SQUARE || state_q == DRAIN) &&
                   (emit_q || final_rnd)) begin
        valid_q <= 1'b1;
        block_q <= red_blk;
        round_q <= ctr_round;
        last_q  <= final_rnd && eor;
      end
    end
  end

  assign block_out = block_q;
  assign valid_out = valid_q;
  assign round_out = round_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_montgomery_square_chain.sv
// Directed bench for the Montgomery squaring chain, N = 2^32-5, R = 2^32.
module tb_montgomery_square_chain;
  localparam int RS = 16;
  localparam int B  = 32;
  localparam int NB = B / RS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] N_in, k_in, block_in = '0, block_out;
  logic        consumed_N_out, consumed_k_out;
  logic        valid_in = 1'b0, ready_out, emit_all_in = 1'b0;
  logic [11:0] num_sq = '0, round_out;
  logic        valid_out, last_out, busy_out;

  logic [31:0] nv = 32'hFFFF_FFFB;
  logic [31:0] kv = 32'hCCCC_CCCD;
  logic        nidx, kidx;

  typedef struct packed {logic [15:0] b; logic [11:0] r; logic l;} rec_t;
  rec_t q[$];
  int   errs = 0, checks = 0, cons_cnt = 0;

  montgomery_square_chain #(
    .REGISTER_SIZE(RS), .BITS_IN_NUM(B), .R(32), .MAX_SQUARINGS(2048)
  ) dut (
    .clk_in(clk), .rst_in(rst), .N_in(N_in), .k_in(k_in),
    .consumed_N_out(consumed_N_out), .consumed_k_out(consumed_k_out),
    .block_in(block_in), .valid_in(valid_in), .ready_out(ready_out),
    .num_squarings_in(num_sq), .emit_all_in(emit_all_in),
    .block_out(block_out), .valid_out(valid_out), .round_out(round_out),
    .last_out(last_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  // N and k block streamers, advancing on each consume strobe.
  assign N_in = nidx ? nv[31:16] : nv[15:0];
  assign k_in = kidx ? kv[31:16] : kv[15:0];
  always @(posedge clk) begin
    if (rst) begin
      nidx <= 1'b0;
      kidx <= 1'b0;
    end else begin
      if (consumed_N_out) nidx <= ~nidx;
      if (consumed_k_out) kidx <= ~kidx;
    end
  end

  // Output recorder and consume-strobe counter.
  always @(negedge clk) begin
    if (valid_out) q.push_back({block_out, round_out, last_out});
    if (consumed_N_out || consumed_k_out) cons_cnt <= cons_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input int idx, input logic [15:0] b,
                         input int r, input bit l);
    chk({tag, "_present"}, 64'(q.size() > idx), 1);
    if (q.size() > idx) begin
      chk({tag, "_blk"}, q[idx].b, b);
      chk({tag, "_rnd"}, q[idx].r, r);
      chk({tag, "_last"}, q[idx].l, l);
    end
  endtask

  // Called at a negedge; leaves at the negedge after the last acceptance.
  task automatic send_op(input logic [31:0] x, input logic [11:0] s, input bit emit);
    int i = 0;
    int guard = 0;
    while (i < NB && guard < 50) begin
      valid_in    = 1'b1;
      block_in    = x[i*16 +: 16];
      num_sq      = s;
      emit_all_in = emit;
      if (ready_out) i++;
      guard++;
      @(negedge clk);
    end
    valid_in = 1'b0;
    chk("send_accepts", i, NB);
  endtask

  task automatic wait_last(input string tag);
    bit ok = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (last_out) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_last_seen"}, ok, 1);
  endtask

  // x = Montgomery 1, S = 7, final round only.
  task automatic exp_t1(input string tag, input int base);
    chk_rec({tag, "_b0"}, base,     16'h0005, 7, 0);
    chk_rec({tag, "_b1"}, base + 1, 16'h0000, 7, 1);
  endtask

  // x = Montgomery 2, S = 3, every round: 4, 16, 256 in Montgomery form.
  task automatic exp_t2(input string tag, input int base);
    logic [15:0] lo;
    for (int i = 0; i < 6; i++) begin
      lo = (i == 0) ? 16'h0014 : (i == 2) ? 16'h0050 : (i == 4) ? 16'h0500 : 16'h0000;
      chk_rec($sformatf("%s_r%0d_b%0d", tag, i/2 + 1, i%2), base + i, lo, i/2 + 1, i == 5);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, ready_out, 1);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_last"}, last_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_block"}, block_out, 0);
    chk({tag, "_round"}, round_out, 0);
    chk({tag, "_consN"}, consumed_N_out, 0);
    chk({tag, "_consK"}, consumed_k_out, 0);
  endtask

  initial begin
    int base, c0;
    bit found;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Test 1: Montgomery 1 squared 7 times stays 1.
    base = q.size();
    send_op(32'h0000_0005, 12'd7, 1'b0);
    chk("t1_busy_run", busy_out, 1);
    chk("t1_ready_run", ready_out, 0);
    wait_last("t1");
    chk("t1_busy_at_last", busy_out, 1);
    chk("t1_ready_at_last", ready_out, 0);
    @(negedge clk);
    chk("t1_busy_after", busy_out, 0);
    chk("t1_ready_after", ready_out, 1);
    chk("t1_count", q.size() - base, 2);
    exp_t1("t1", base);

    // Test 2: every round visible.
    base = q.size();
    send_op(32'h0000_000A, 12'd3, 1'b1);
    wait_last("t2");
    @(negedge clk);
    chk("t2_count", q.size() - base, 6);
    exp_t2("t2", base);

    // Test 3: S = 0 pass-through, reducer never engaged.
    c0 = cons_cnt;
    base = q.size();
    valid_in = 1'b1; block_in = 16'hABCD; num_sq = '0; emit_all_in = 1'b0;
    @(negedge clk);
    chk("t3_v0", valid_out, 1);
    chk("t3_b0", block_out, 16'hABCD);
    chk("t3_r0", round_out, 0);
    chk("t3_l0", last_out, 0);
    block_in = 16'h1234;
    @(negedge clk);
    valid_in = 1'b0;
    chk("t3_v1", valid_out, 1);
    chk("t3_b1", block_out, 16'h1234);
    chk("t3_r1", round_out, 0);
    chk("t3_l1", last_out, 1);
    chk("t3_ready_at_last", ready_out, 0);
    @(negedge clk);
    chk("t3_v_after", valid_out, 0);
    chk("t3_ready_after", ready_out, 1);
    chk("t3_busy_after", busy_out, 0);
    repeat (10) @(negedge clk);
    chk("t3_no_consume", cons_cnt - c0, 0);
    chk("t3_count", q.size() - base, 2);

    // Test 4: stray input during squaring is ignored.
    base = q.size();
    send_op(32'h0000_000A, 12'd3, 1'b1);
    valid_in = 1'b1; block_in = 16'hDEAD;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t4_ready_sq%0d", i), ready_out, 0);
    end
    valid_in = 1'b0;
    wait_last("t4");
    @(negedge clk);
    chk("t4_count", q.size() - base, 6);
    exp_t2("t4", base);

    // Test 5: reset in round 2, then a clean Montgomery-1 run.
    send_op(32'h0000_000A, 12'd3, 1'b1);
    found = 0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      if (valid_out && round_out == 12'd2) found = 1;
    end
    chk("t5_round2_seen", found, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("t5_rst");
    rst = 1'b0;
    base = q.size();
    @(negedge clk);
    send_op(32'h0000_0005, 12'd7, 1'b0);
    wait_last("t5");
    @(negedge clk);
    chk("t5_count", q.size() - base, 2);
    exp_t1("t5", base);

    // Test 6: back-to-back, second op starts the cycle after last_out.
    base = q.size();
    send_op(32'h0000_000A, 12'd3, 1'b1);
    wait_last("t6a");
    chk("t6_ready_at_last", ready_out, 0);
    @(negedge clk);
    chk("t6_ready_next", ready_out, 1);
    send_op(32'h0000_0005, 12'd7, 1'b0);
    wait_last("t6b");
    @(negedge clk);
    chk("t6_count", q.size() - base, 8);
    exp_t2("t6a", base);
    exp_t1("t6b", base + 6);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
